// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed little-endian data memory with
// combinational loads, clocked stores, memory-error detection, status
// generation and a sticky freeze after the first non-AOK instruction.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   m_icode       icode of the instruction in this stage
//   m_bubble      slot holds a bubble (no access, no status)
//   m_hlt         instruction is halt
//   m_in_inst     instruction was invalid
//   m_valE        ALU result / address for rmmovq, mrmovq, call, pushq
//   m_valA        store data / address for ret, popq
//   m_valP        return address stored by call
//   m_valM        load result (combinational)
//   m_in_mem      address error on this access (combinational)
//   m_stat        0=AOK 1=HLT 2=ADR 3=INS (combinational)
//   frozen        sticky store disable, cleared only by reset
//   st_count      committed stores since reset, wrapping
module memory_stage #(
    parameter int unsigned DMEM_BYTES = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       m_icode,
    input  logic             m_bubble,
    input  logic             m_hlt,
    input  logic             m_in_inst,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valA,
    input  logic [63:0]      m_valP,
    output logic [63:0]      m_valM,
    output logic             m_in_mem,
    output logic [1:0]       m_stat,
    output logic             frozen,
    output logic [CNT_W-1:0] st_count
);

    localparam int unsigned AW       = $clog2(DMEM_BYTES);
    localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    logic [7:0]    mem [DMEM_BYTES];
    logic          is_wr_c;
    logic          is_rd_c;
    logic          mem_err_c;
    logic          store_en_c;
    logic [63:0]   addr_c;
    logic [63:0]   wdata_c;
    logic [AW-1:0] idx_c;

    // Access decode, address/data select and bounds check
    always_comb begin
        is_wr_c   = (m_icode == I_RMMOVQ) || (m_icode == I_CALL) || (m_icode == I_PUSHQ);
        is_rd_c   = (m_icode == I_MRMOVQ) || (m_icode == I_RET)  || (m_icode == I_POPQ);
        addr_c    = ((m_icode == I_RET) || (m_icode == I_POPQ)) ? m_valA : m_valE;
        wdata_c   = (m_icode == I_CALL) ? m_valP : m_valA;
        mem_err_c = !m_bubble && (is_wr_c || is_rd_c) && (addr_c > ADDR_MAX);
        idx_c     = addr_c[AW-1:0];
    end

    assign m_in_mem = mem_err_c;

    // Zero-latency little-endian load; reads pre-store contents
    always_comb begin
        m_valM = '0;
        if (!m_bubble && is_rd_c && !mem_err_c) begin
            for (int i = 0; i < 8; i++) begin
                m_valM[8*i +: 8] = mem[idx_c + AW'(i)];
            end
        end
    end

    // Status priority: invalid instruction, address error, halt
    always_comb begin
        m_stat = STAT_AOK;
        if (!m_bubble) begin
            if (m_in_inst)      m_stat = STAT_INS;
            else if (mem_err_c) m_stat = STAT_ADR;
            else if (m_hlt)     m_stat = STAT_HLT;
        end
    end

    // Reset level gates stores so an edge during reset never writes
    assign store_en_c = rst_n && !m_bubble && is_wr_c && !mem_err_c &&
                        !frozen && !m_hlt && !m_in_inst;

    // Data memory write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (store_en_c) begin
            for (int i = 0; i < 8; i++) begin
                mem[idx_c + AW'(i)] <= wdata_c[8*i +: 8];
            end
        end
    end

    // Sticky freeze and committed-store counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen   <= 1'b0;
            st_count <= '0;
        end else begin
            if (store_en_c) st_count <= st_count + CNT_W'(1);
            if (!m_bubble && (m_stat != STAT_AOK)) frozen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a random
// instruction stream checked against a byte-array reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m_icode;
    logic        m_bubble;
    logic        m_hlt;
    logic        m_in_inst;
    logic [63:0] m_valE;
    logic [63:0] m_valA;
    logic [63:0] m_valP;
    logic [63:0] m_valM;
    logic        m_in_mem;
    logic [1:0]  m_stat;
    logic        frozen;
    logic [15:0] st_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_stage #(.DMEM_BYTES(1024), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .m_icode(m_icode), .m_bubble(m_bubble),
        .m_hlt(m_hlt), .m_in_inst(m_in_inst), .m_valE(m_valE), .m_valA(m_valA),
        .m_valP(m_valP), .m_valM(m_valM), .m_in_mem(m_in_mem), .m_stat(m_stat),
        .frozen(frozen), .st_count(st_count)
    );

    // Reference model: memory as bytes plus "has been written" flags
    logic [7:0]  mdl [1024];
    bit          known [1024];
    bit          mfrozen = 1'b0;
    int unsigned mcnt = 0;

    // Expectations for the instruction currently driven
    logic [63:0] ex_valM;
    bit          ex_known;
    bit          ex_err;
    logic [1:0]  ex_stat;
    bit          ex_commit;
    bit          ex_freeze;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mdl[i]   = 8'h00;
            known[i] = 1'b0;
        end
    end

    // Apply one instruction and compute what the stage should do with it
    task automatic drive(input logic [3:0] ic, input bit bub, input bit hlt, input bit inst,
                         input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp);
        bit wr, rd;
        m_icode = ic; m_bubble = bub; m_hlt = hlt; m_in_inst = inst;
        m_valE = ve; m_valA = va; m_valP = vp;
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        ex_addr  = (ic == 4'h9 || ic == 4'hB) ? va : ve;
        ex_wdata = (ic == 4'h8) ? vp : va;
        ex_err   = !bub && (wr || rd) && (ex_addr > 64'd1016);
        ex_valM  = 64'd0;
        ex_known = 1'b1;
        if (!bub && rd && !ex_err) begin
            for (int i = 0; i < 8; i++) begin
                ex_valM  = ex_valM | (64'(mdl[int'(ex_addr) + i]) << (8 * i));
                ex_known = ex_known && known[int'(ex_addr) + i];
            end
        end
        if (bub)         ex_stat = 2'd0;
        else if (inst)   ex_stat = 2'd3;
        else if (ex_err) ex_stat = 2'd2;
        else if (hlt)    ex_stat = 2'd1;
        else             ex_stat = 2'd0;
        ex_commit = wr && !ex_err && !bub && !mfrozen && !hlt && !inst;
        ex_freeze = !bub && (ex_stat != 2'd0);
        #1;
    endtask

    // Clock the driven instruction in and advance the model; ends at negedge
    task automatic tick();
        @(posedge clk);
        if (ex_commit) begin
            for (int i = 0; i < 8; i++) begin
                mdl[int'(ex_addr) + i]   = ex_wdata[8*i +: 8];
                known[int'(ex_addr) + i] = 1'b1;
            end
            mcnt = (mcnt + 1) % 65536;
        end
        if (ex_freeze) mfrozen = 1'b1;
        @(negedge clk);
    endtask

    // Short reset pulse between edges; called right after a negedge
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        mfrozen = 1'b0;
        mcnt    = 0;
        rst_n   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'h1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        #2;
        n_tests++;
        if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen got %0b want 0", frozen); end
        n_tests++;
        if (st_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", st_count); end
        @(negedge clk);
        rst_n = 1'b1;
        mfrozen = 1'b0; mcnt = 0;
    endtask

    task automatic test_round_trip();
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd16, 64'h1122334455667788, 64'd0);
        n_tests++;
        if (m_in_mem !== 1'b0 || m_stat !== 2'd0 || m_valM !== 64'd0) begin
            n_fail++; $display("FAIL rt_store_comb err=%0b stat=%0d valM=%h want 0/0/0", m_in_mem, m_stat, m_valM);
        end
        tick();
        n_tests++;
        if (st_count !== 16'd1) begin n_fail++; $display("FAIL rt_count got %0d want 1", st_count); end
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'd16, 64'd0, 64'd0);
        n_tests++;
        if (m_valM !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL rt_load got %h want 1122334455667788", m_valM);
        end
        n_tests++;
        if (m_valM[7:0] !== 8'h88) begin n_fail++; $display("FAIL rt_byte16 got %h want 88", m_valM[7:0]); end
        tick();
        // Overwrite, then read: new value visible only the cycle after
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd16, 64'hCAFEF00DDEADBEEF, 64'd0);
        tick();
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'd20, 64'd0, 64'd0);
        n_tests++;
        if (m_valM[31:0] !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL rt_unaligned got %h want low word cafef00d", m_valM[31:0]);
        end
        tick();
    endtask

    task automatic test_stack();
        drive(4'hA, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd42, 64'd0);
        tick();
        drive(4'hB, 1'b0, 1'b0, 1'b0, 64'd8, 64'd1000, 64'd0);
        n_tests++;
        if (m_valM !== 64'd42) begin n_fail++; $display("FAIL stack_pop got %0d want 42", m_valM); end
        tick();
        drive(4'h8, 1'b0, 1'b0, 1'b0, 64'd992, 64'h5555, 64'h40);
        tick();
        drive(4'h9, 1'b0, 1'b0, 1'b0, 64'd0, 64'd992, 64'd0);
        n_tests++;
        if (m_valM !== 64'h40) begin n_fail++; $display("FAIL stack_ret got %h want 40", m_valM); end
        tick();
        n_tests++;
        if (st_count !== 16'(mcnt)) begin n_fail++; $display("FAIL stack_count got %0d want %0d", st_count, mcnt); end
    endtask

    task automatic test_bounds();
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd1016, 64'h0102030405060708, 64'd0);
        tick();
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'd1016, 64'd0, 64'd0);
        n_tests++;
        if (m_in_mem !== 1'b0 || m_valM !== 64'h0102030405060708) begin
            n_fail++; $display("FAIL bnd_1016 err=%0b valM=%h want 0/0102030405060708", m_in_mem, m_valM);
        end
        tick();
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd1017, 64'hFFFF, 64'd0);
        n_tests++;
        if (m_in_mem !== 1'b1 || m_stat !== 2'd2) begin
            n_fail++; $display("FAIL bnd_1017 err=%0b stat=%0d want 1/2", m_in_mem, m_stat);
        end
        tick();
        n_tests++;
        if (frozen !== 1'b1 || st_count !== 16'(mcnt)) begin
            n_fail++; $display("FAIL bnd_freeze frozen=%0b cnt=%0d want 1/%0d", frozen, st_count, mcnt);
        end
        pulse_reset();
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
        n_tests++;
        if (m_in_mem !== 1'b1 || m_valM !== 64'd0) begin
            n_fail++; $display("FAIL bnd_neg err=%0b valM=%h want 1/0", m_in_mem, m_valM);
        end
        // popq addresses through valA even when valE is legal
        drive(4'hB, 1'b0, 1'b0, 1'b0, 64'd0, 64'd2000, 64'd0);
        n_tests++;
        if (m_in_mem !== 1'b1) begin n_fail++; $display("FAIL bnd_pop_valA err=%0b want 1", m_in_mem); end
        drive(4'h1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        tick();
    endtask

    task automatic test_freeze();
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd0, 64'hA5A5_0000_1234_5678, 64'd0);
        tick();
        drive(4'h0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        n_tests++;
        if (m_stat !== 2'd1) begin n_fail++; $display("FAIL frz_halt_stat got %0d want 1", m_stat); end
        tick();
        n_tests++;
        if (frozen !== 1'b1) begin n_fail++; $display("FAIL frz_set got %0b want 1", frozen); end
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd0, 64'hDEAD, 64'd0);
        tick();
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        n_tests++;
        if (m_valM !== 64'hA5A5_0000_1234_5678 || st_count !== 16'(mcnt)) begin
            n_fail++; $display("FAIL frz_nostore valM=%h cnt=%0d want a5a5000012345678/%0d", m_valM, st_count, mcnt);
        end
        tick();
        pulse_reset();
        n_tests++;
        if (frozen !== 1'b0) begin n_fail++; $display("FAIL frz_clear got %0b want 0", frozen); end
    endtask

    task automatic test_bubbles();
        drive(4'h4, 1'b1, 1'b0, 1'b0, 64'd64, 64'h77, 64'd0);
        n_tests++;
        if (m_stat !== 2'd0 || m_in_mem !== 1'b0) begin
            n_fail++; $display("FAIL bub_comb stat=%0d err=%0b want 0/0", m_stat, m_in_mem);
        end
        tick();
        n_tests++;
        if (st_count !== 16'(mcnt) || frozen !== 1'b0) begin
            n_fail++; $display("FAIL bub_nostore cnt=%0d frozen=%0b want %0d/0", st_count, frozen, mcnt);
        end
        drive(4'h4, 1'b0, 1'b0, 1'b1, 64'd5000, 64'd1, 64'd0);
        n_tests++;
        if (m_stat !== 2'd3 || m_in_mem !== 1'b1) begin
            n_fail++; $display("FAIL bub_ins_adr stat=%0d err=%0b want 3/1", m_stat, m_in_mem);
        end
        tick();
        pulse_reset();
        // Halting store commits nothing
        drive(4'h4, 1'b0, 1'b1, 1'b0, 64'd64, 64'd9, 64'd0);
        tick();
        n_tests++;
        if (st_count !== 16'd0 || frozen !== 1'b1) begin
            n_fail++; $display("FAIL bub_hlt_store cnt=%0d frozen=%0b want 0/1", st_count, frozen);
        end
        pulse_reset();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'h4, 1'b0, 1'b0, 1'b0, 64'(200 + 8 * i), 64'(1000 + i), 64'd0);
            tick();
        end
        n_tests++;
        if (st_count !== 16'd5) begin n_fail++; $display("FAIL ar_count5 got %0d want 5", st_count); end
        // Store held under reset across a posedge must not land
        drive(4'h4, 1'b0, 1'b0, 1'b0, 64'd200, 64'hBAD, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (st_count !== 16'd0) begin n_fail++; $display("FAIL ar_immediate got %0d want 0", st_count); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0; mfrozen = 1'b0;
        drive(4'h5, 1'b0, 1'b0, 1'b0, 64'd200, 64'd0, 64'd0);
        n_tests++;
        if (m_valM !== 64'd1000 || st_count !== 16'd0) begin
            n_fail++; $display("FAIL ar_inhibit valM=%0d cnt=%0d want 1000/0", m_valM, st_count);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  ic;
        logic [63:0] a;
        bit bub, hlt, inst;
        int r;
        for (int n = 0; n < 400; n++) begin
            if (mfrozen && $urandom_range(0, 3) == 0) pulse_reset();
            ic   = 4'($urandom_range(0, 15));
            bub  = ($urandom_range(0, 7) == 0);
            hlt  = ($urandom_range(0, 29) == 0);
            inst = ($urandom_range(0, 29) == 0);
            r    = int'($urandom_range(0, 9));
            if (r < 7)       a = 64'($urandom_range(0, 120));
            else if (r < 9)  a = 64'($urandom_range(0, 1023));
            else             a = {32'($urandom), 32'($urandom)};
            if (ic == 4'h9 || ic == 4'hB)
                drive(ic, bub, hlt, inst, 64'($urandom), a, 64'($urandom));
            else
                drive(ic, bub, hlt, inst, a, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
            n_tests++;
            if (m_in_mem !== ex_err || m_stat !== ex_stat) begin
                n_fail++; $display("FAIL rnd_status n=%0d err=%0b stat=%0d want %0b/%0d", n, m_in_mem, m_stat, ex_err, ex_stat);
            end
            if (ex_known) begin
                n_tests++;
                if (m_valM !== ex_valM) begin
                    n_fail++; $display("FAIL rnd_load n=%0d got %h want %h", n, m_valM, ex_valM);
                end
            end
            tick();
            n_tests++;
            if (frozen !== mfrozen || st_count !== 16'(mcnt)) begin
                n_fail++; $display("FAIL rnd_regs n=%0d frozen=%0b cnt=%0d want %0b/%0d", n, frozen, st_count, mfrozen, mcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_stack();
        test_bounds();
        test_freeze();
        test_bubbles();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
